// File: rtl/seq_match_monitor.sv
// ---------------------------------------------------------------------------
// seq_match_monitor
//
// Consumer of the serial sequence detector's registered match pulse. It
// counts matches, measures the cycle gap between consecutive matches, and
// raises a level interrupt each time a programmable number of matches has
// accumulated. The interrupt is held until it is acknowledged. It sits
// between the detector and the control/status register block.
//
// Compile-time option:
//   SEQ_MON_GAP_EN  defined   -> gap measurement (gap_cnt/last_gap) built in
//                   undefined -> gap logic removed, last_gap tied to 0
//
// Parameters:
//   CNT_W  width of total match counter, window counter and threshold
//   GAP_W  width of gap counter and last_gap
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   en         in   1      monitor enable; 0 freezes counters
//   match_in   in   1      1-cycle match pulse from detector
//   clr        in   1      synchronous clear of all counters/flags
//   thresh     in   CNT_W  matches per interrupt; 0 = interrupts disabled
//   irq_ack    in   1      interrupt acknowledge, 1-cycle pulse
//   match_cnt  out  CNT_W  total matches, saturates at all-ones
//   last_gap   out  GAP_W  cycles between last two matches, saturating
//   irq        out  1      interrupt level, held until acknowledged
//   overflow   out  1      sticky: threshold hit while irq already pending
// ---------------------------------------------------------------------------
module seq_match_monitor #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             match_in,
  input  logic             clr,
  input  logic [CNT_W-1:0] thresh,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] match_cnt,
  output logic [GAP_W-1:0] last_gap,
  output logic             irq,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALERT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_cnt_nxt;
  logic [CNT_W-1:0] match_cnt_nxt;
  logic             overflow_nxt;

  // Counting happens only in ARMED/ALERT with the monitor enabled. An IDLE
  // cycle that sees en=1 only arms the monitor; its match is ignored.
  logic             counting;
  logic             match_ev;
  logic             hit;
  logic [CNT_W:0]   win_inc;

  assign counting = (state != IDLE) && en;

  // clr has priority over a same-cycle match, so the match is dropped.
  assign match_ev = counting && match_in && !clr;

  // One extra bit keeps win_cnt+1 from wrapping to 0 at all-ones. That way a
  // thresh lowered below the current window count still hits on the next
  // match.
  assign win_inc  = {1'b0, win_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign hit      = match_ev && (thresh != '0) && (win_inc >= {1'b0, thresh});

  // The interrupt is exactly "in ALERT". Decoding it from the state register
  // keeps irq glitch-free and impossible to desynchronise from the FSM.
  assign irq = (state == ALERT);

  // -------------------------------------------------------------------------
  // Next-state / next-counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_nxt     = state;
    win_cnt_nxt   = win_cnt;
    match_cnt_nxt = match_cnt;
    overflow_nxt  = overflow;

    if (clr) begin
      state_nxt     = en ? ARMED : IDLE;
      win_cnt_nxt   = '0;
      match_cnt_nxt = '0;
      overflow_nxt  = 1'b0;
    end else begin
      if (match_ev) begin
        if (match_cnt != CNT_MAX) begin
          match_cnt_nxt = match_cnt + 1'b1;
        end
        // With thresh=0 the window simply keeps counting and wraps.
        win_cnt_nxt = hit ? '0 : win_inc[CNT_W-1:0];
      end

      unique case (state)
        IDLE: begin
          if (en) state_nxt = ARMED;
        end
        ARMED: begin
          if (!en)      state_nxt = IDLE;
          else if (hit) state_nxt = ALERT;
        end
        ALERT: begin
          if (irq_ack) begin
            // A hit on the acknowledge edge re-raises the interrupt at once,
            // so the FSM stays in ALERT and overflow is not flagged.
            if (!hit) state_nxt = en ? ARMED : IDLE;
          end else if (hit) begin
            overflow_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      win_cnt   <= '0;
      match_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so all
      // registers see the same pre-edge values regardless of statement order.
      state     <= state_nxt;
      win_cnt   <= win_cnt_nxt;
      match_cnt <= match_cnt_nxt;
      overflow  <= overflow_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Gap measurement
  // -------------------------------------------------------------------------
`ifdef SEQ_MON_GAP_EN
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  logic [GAP_W-1:0] gap_cnt;
  // seen marks that a first match has occurred since reset/clr. Until then
  // there is no previous match to measure a gap from.
  logic             seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt  <= '0;
      last_gap <= '0;
      seen     <= 1'b0;
    end else if (clr) begin
      gap_cnt  <= '0;
      last_gap <= '0;
      seen     <= 1'b0;
    end else if (counting) begin
      if (match_in) begin
        gap_cnt <= '0;
        seen    <= 1'b1;
        // The gap includes the match cycle itself, saturating at all-ones.
        if (seen) begin
          last_gap <= (gap_cnt == GAP_MAX) ? GAP_MAX : gap_cnt + 1'b1;
        end
      end else if (gap_cnt != GAP_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end
`else
  assign last_gap = '0;
`endif

endmodule

// File: tb/tb_seq_match_monitor.sv
// ---------------------------------------------------------------------------
// tb_seq_match_monitor
//
// Randomized, scoreboarded bench for seq_match_monitor. The driver applies
// inputs on the falling edge and advances a behavioural model of the
// monitor. It then queues the outputs expected after the next rising edge.
// A separate monitor process pops the queue shortly after every rising edge
// and compares. Small counter widths make match_cnt and last_gap saturation
// reachable. Asynchronous reset is asserted mid-run and checked immediately.
// ---------------------------------------------------------------------------
module tb_seq_match_monitor;

  localparam int CNT_W   = 6;
  localparam int GAP_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int GAP_MAX = (1 << GAP_W) - 1;
`ifdef SEQ_MON_GAP_EN
  localparam bit GAP_EN  = 1'b1;
`else
  localparam bit GAP_EN  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             match_in;
  logic             clr;
  logic [CNT_W-1:0] thresh;
  logic             irq_ack;
  logic [CNT_W-1:0] match_cnt;
  logic [GAP_W-1:0] last_gap;
  logic             irq;
  logic             overflow;

  seq_match_monitor #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .match_in (match_in),
    .clr      (clr),
    .thresh   (thresh),
    .irq_ack  (irq_ack),
    .match_cnt(match_cnt),
    .last_gap (last_gap),
    .irq      (irq),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] match_cnt;
    logic [GAP_W-1:0] last_gap;
    logic             irq;
    logic             overflow;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model. It tracks whether the monitor is running and whether
  // an interrupt is pending, plus plain integer totals. Saturation is applied
  // only when an output value is formed.
  // -------------------------------------------------------------------------
  bit m_run, m_irq, m_ovf, m_seen;
  int m_total, m_win, m_gap, m_last;

  task automatic model_reset();
    m_run = 0; m_irq = 0; m_ovf = 0; m_seen = 0;
    m_total = 0; m_win = 0; m_gap = 0; m_last = 0;
  endtask

  task automatic model_step(input bit en_i, input bit match_i, input bit clr_i,
                            input bit ack_i, input int th);
    bit counting;
    bit hit;
    if (clr_i) begin
      model_reset();
      m_run = en_i;
      return;
    end
    counting = m_run && en_i;
    hit = 0;
    if (counting) begin
      if (match_i) begin
        m_total++;
        if (th != 0 && m_win + 1 >= th) begin
          hit = 1;
          m_win = 0;
        end else begin
          m_win = (m_win + 1) % (CNT_MAX + 1);
        end
        if (m_seen) m_last = (m_gap + 1 > GAP_MAX) ? GAP_MAX : m_gap + 1;
        m_seen = 1;
        m_gap = 0;
      end else begin
        m_gap++;
      end
    end
    if (m_irq) begin
      if (ack_i) begin
        if (!hit) begin
          m_irq = 0;
          m_run = en_i;
        end
      end else if (hit) begin
        m_ovf = 1;
      end
    end else if (m_run) begin
      if (!en_i)    m_run = 0;
      else if (hit) m_irq = 1;
    end else begin
      m_run = en_i;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.match_cnt = CNT_W'((m_total > CNT_MAX) ? CNT_MAX : m_total);
    e.last_gap  = GAP_EN ? GAP_W'(m_last) : '0;
    e.irq       = m_irq;
    e.overflow  = m_ovf;
    return e;
  endfunction

  // -------------------------------------------------------------------------
  // Monitor: compares DUT outputs against the queued expectation each cycle
  // -------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("match_cnt", 32'(match_cnt), 32'(e.match_cnt));
        check("last_gap",  32'(last_gap),  32'(e.last_gap));
        check("irq",       32'(irq),       32'(e.irq));
        check("overflow",  32'(overflow),  32'(e.overflow));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_match_cnt"}, 32'(match_cnt), 32'd0);
    check({tag, "_last_gap"},  32'(last_gap),  32'd0);
    check({tag, "_irq"},       32'(irq),       32'd0);
    check({tag, "_overflow"},  32'(overflow),  32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Driver
  // -------------------------------------------------------------------------
  int p_match, p_en, p_clr, p_ack, p_th_chg, th_lo, th_hi;

  task automatic drive_cycle();
    en       = ($urandom_range(99) < p_en);
    match_in = ($urandom_range(99) < p_match);
    clr      = ($urandom_range(99) < p_clr);
    irq_ack  = ($urandom_range(99) < p_ack);
    if ($urandom_range(99) < p_th_chg) thresh = CNT_W'($urandom_range(th_hi, th_lo));
    model_step(en, match_in, clr, irq_ack, int'(thresh));
    sb_q.push_back(model_out());
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; match_in = 1'b0; clr = 1'b0; irq_ack = 1'b0; thresh = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    for (int p = 0; p < 16; p++) begin
      unique case (p % 4)
        0: begin  // dense matches, no clear: drives match_cnt to saturation
          p_match = 70; p_en = 97; p_clr = 0; p_ack = 15; p_th_chg = 4; th_lo = 1; th_hi = 5;
        end
        1: begin  // sparse matches: long gaps, last_gap saturation
          p_match = 4;  p_en = 98; p_clr = 0; p_ack = 30; p_th_chg = 2; th_lo = 1; th_hi = 2;
        end
        2: begin  // mixed traffic with clears, enables and disabled threshold
          p_match = 30; p_en = 85; p_clr = 3; p_ack = 25; p_th_chg = 5; th_lo = 0; th_hi = 7;
        end
        default: begin  // large thresholds dropped abruptly below win_cnt
          p_match = 50; p_en = 95; p_clr = 1; p_ack = 40; p_th_chg = 6; th_lo = 1; th_hi = 40;
        end
      endcase
      for (int c = 0; c < 350; c++) begin
        @(negedge clk);
        if (c == 0 && p % 3 == 2) begin
          // Asynchronous reset mid-run: outputs must clear without a clock edge.
          rst = 1'b1;
          en = 1'b0; match_in = 1'b0; clr = 1'b0; irq_ack = 1'b0;
          #1;
          check_reset_outputs("async_rst");
          model_reset();
          @(negedge clk);
          rst = 1'b0;
        end
        drive_cycle();
      end
    end

    @(negedge clk);
    en = 1'b0; match_in = 1'b0; clr = 1'b0; irq_ack = 1'b0;
    @(posedge clk);
    #2;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
